// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: receive-controller state encoding and sync pattern shared across the RX path
package usb_rx_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    BYTE_WAIT,
    STORE,
    EOP_WAIT,
    ERR_WAIT,
    ERR_IDLE
  } rx_state_e;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
endpackage

// File: rtl/rx_bit_cnt.sv
// rx_bit_cnt: 3-bit bit-position counter with clear priority over count
module rx_bit_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count_en,
  output logic [2:0] count
);
  logic [2:0] count_q, count_d;
  always_comb count_d = clear ? 3'd0 : count_en ? count_q + 3'd1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? 3'd0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/rx_ctrl.sv
// rx_ctrl: packet receive FSM driving timer enable, FIFO write strobe and sticky error flag
module rx_ctrl
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_en,
  input  logic       byte_rcvd,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);
  rx_state_e  state_q, state_d;
  logic       r_error_q, r_error_d;
  logic [2:0] bit_cnt;
  logic       eop_shift, pkt_start;
  assign eop_shift = eop & shift_en;
  assign pkt_start = (state_q == IDLE) & d_edge;
  rx_bit_cnt u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (pkt_start | byte_rcvd),
    .count_en (shift_en & rcving & ~byte_rcvd),
    .count    (bit_cnt)
  );
  always_ff @(posedge clk) begin
    state_q   <= rst ? IDLE : state_d;
    r_error_q <= rst ? 1'b0 : r_error_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = d_edge ? SYNC_WAIT : IDLE;
      SYNC_WAIT: state_d = byte_rcvd ? SYNC_CHK : eop_shift ? ERR_WAIT : SYNC_WAIT;
      SYNC_CHK:  state_d = (rcv_data == SYNC_BYTE) ? BYTE_WAIT : ERR_WAIT;
      BYTE_WAIT: state_d = eop_shift ? ((byte_rcvd || bit_cnt != 3'd0) ? ERR_WAIT : EOP_WAIT)
                                     : byte_rcvd ? STORE : BYTE_WAIT;
      STORE:     state_d = BYTE_WAIT;
      EOP_WAIT:  state_d = d_edge ? IDLE : EOP_WAIT;
      ERR_WAIT:  state_d = eop_shift ? ERR_IDLE : ERR_WAIT;
      ERR_IDLE:  state_d = d_edge ? IDLE : ERR_IDLE;
      default:   state_d = IDLE;
    endcase
    r_error_d = pkt_start ? 1'b0 : (state_d == ERR_WAIT) ? 1'b1 : r_error_q;
  end
  always_comb begin
    rcving   = (state_q != IDLE) && (state_q != ERR_IDLE);
    w_enable = state_q == STORE;
    r_error  = r_error_q;
  end
endmodule

// File: doc/rx_ctrl.md
RX_CTRL -- requirements
Module: rx_ctrl

Interface
REQ-001 SYNC_BYTE, 8'h80, expected first byte of every packet (LSB-first sync pattern as assembled by the shift register).
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 d_edge  in  1  single-cycle pulse on any D+/D- transition, from edge detector.
REQ-005 eop  in  1  level; end-of-packet (SE0) currently present on the bus.
REQ-006 shift_en  in  1  single-cycle pulse per bit-sampling point, from timer.
REQ-007 byte_rcvd  in  1  single-cycle pulse when timer has counted 8 bits.
REQ-008 rcv_data  in  8  current shift-register contents.
REQ-009 rcving  out  1  packet reception in progress; also the timer's enable.
REQ-010 w_enable  out  1  single-cycle FIFO write strobe for rcv_data.
REQ-011 r_error  out  1  receive error flag, sticky until next packet start.

Function
REQ-012 All outputs SHALL be registered Moore outputs decoded from the state register (plus r_error flop); one-cycle latency from the causing input.
REQ-013 States SHALL be IDLE, SYNC_WAIT, SYNC_CHK, BYTE_WAIT, STORE, EOP_WAIT, ERR_WAIT, ERR_IDLE.
REQ-014 IDLE: d_edge -> SYNC_WAIT, clearing r_error the same edge; else hold.
REQ-015 SYNC_WAIT: byte_rcvd -> SYNC_CHK; eop&shift_en -> ERR_WAIT.
REQ-016 SYNC_CHK: rcv_data==SYNC_BYTE -> BYTE_WAIT; otherwise -> ERR_WAIT.
REQ-017 BYTE_WAIT: byte_rcvd and not (eop&shift_en) -> STORE; eop&shift_en with bit count 0 -> EOP_WAIT; eop&shift_en with bit count nonzero, or together with byte_rcvd -> ERR_WAIT.
REQ-018 STORE: w_enable=1 for exactly this one cycle; unconditional -> BYTE_WAIT.
REQ-019 EOP_WAIT: d_edge (bus returns to idle J) -> IDLE; r_error stays 0.
REQ-020 ERR_WAIT: r_error set on entry; eop&shift_en -> ERR_IDLE; d_edge ignored.
REQ-021 ERR_IDLE: d_edge -> IDLE; r_error stays 1.
REQ-022 rcving SHALL be 1 in SYNC_WAIT, SYNC_CHK, BYTE_WAIT, STORE, EOP_WAIT, ERR_WAIT; 0 in IDLE and ERR_IDLE.
REQ-023 Bit counter: 3-bit, cleared on entry to SYNC_WAIT and on byte_rcvd, incremented on shift_en while rcving=1 and not byte_rcvd; wraps 7->0 silently.
REQ-024 Simultaneous byte_rcvd and shift_en in BYTE_WAIT: byte_rcvd wins for counter (clear).
REQ-025 A byte completing while in STORE is impossible by timer spacing (>=8 clocks per bit); no buffering required.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, rcving=0, w_enable=0, r_error=0, bit count 0, from any state including mid-packet.
REQ-027 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-028 Package usb_rx_pkg SHALL hold the state enum type and SYNC_BYTE constant; shared with timer and FIFO benches.
REQ-029 The bit counter SHALL be one sub-module, rx_bit_cnt (clk, rst, clear, count_en, count[2:0]).
REQ-030 No other sub-modules; FSM next-state and output decode in rx_ctrl.

Verification
REQ-031 Reset mid-BYTE_WAIT: rst pulse -> next cycle rcving=0, w_enable=0, r_error=0, state IDLE.
REQ-032 Good packet: d_edge, sync 8'h80, two data bytes 8'hA5 8'h3C, then eop&shift_en at count 0 -> exactly two w_enable pulses, r_error=0, rcving drops one cycle after closing d_edge.
REQ-033 Bad sync: rcv_data 8'h81 at first byte_rcvd -> r_error=1 next cycle, no w_enable, rcving=0 after eop&shift_en, r_error held until next packet's d_edge.
REQ-034 Short byte: after sync and 3 shift_en pulses, eop&shift_en -> r_error=1, no w_enable for the partial byte.
REQ-035 Collision: byte_rcvd and eop&shift_en same cycle in BYTE_WAIT -> ERR_WAIT, r_error=1, w_enable stays 0.
REQ-036 Error recovery: after ERR_IDLE, fresh good packet -> r_error cleared at its first d_edge, normal writes follow.
